// File: rtl/register_file_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file: read ports,
// write ports, reservation request and the full busy scoreboard.
interface register_file_mp_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_reg;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]                 rd_busy;
    logic [NUM_WR_PORTS-1:0]                 wr_en;
    logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]     wr_reg;
    logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;
    logic                                    rsv_en;
    logic [ADDR_W-1:0]                       rsv_reg;
    logic [NUM_REGS-1:0]                     busy_vec;

    modport master (
        output rd_reg, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_reg, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/register_file_mp.sv
// Parametrised multi-port integer register file with x0 hardwired to zero,
// optional same-cycle write bypass and a per-register pending-writeback scoreboard.
module register_file_mp #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    parameter int BYPASS       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    register_file_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]     mem;
    logic [NUM_REGS-1:0]                     busy;
    logic [NUM_REGS-1:0]                     busyNext;
    logic [NUM_RD_PORTS-1:0]                 fwdHit;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] fwdData;

    // Ports are visited in ascending order so the highest-indexed writer to an address lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (bus.wr_en[p] && bus.wr_reg[p] != ADDR_W'(0)) begin
                    mem[bus.wr_reg[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    // Reservation is applied after the write clears: a newer producer keeps the register pending.
    always_comb begin
        busyNext = busy;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (bus.wr_en[p]) begin
                busyNext[bus.wr_reg[p]] = 1'b0;
            end
        end
        if (bus.rsv_en) begin
            busyNext[bus.rsv_reg] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    always_comb begin
        fwdHit  = '0;
        fwdData = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
                if (BYPASS != 0 && bus.wr_en[w] && bus.wr_reg[w] == bus.rd_reg[r]) begin
                    fwdHit[r]  = 1'b1;
                    fwdData[r] = bus.wr_data[w];
                end
            end
        end
    end

    // Bypassed data must not leak out while reset holds the array at zero.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            if (rst_n && bus.rd_reg[r] != ADDR_W'(0)) begin
                bus.rd_data[r] = fwdHit[r] ? fwdData[r] : mem[bus.rd_reg[r]];
                bus.rd_busy[r] = busy[bus.rd_reg[r]] &&
                                 !(fwdHit[r] && !(bus.rsv_en && bus.rsv_reg == bus.rd_reg[r]));
            end
        end
    end

    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared against directed vectors and an array-based reference model.
module tb_register_file_mp;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    typedef struct {
        logic [1:0]    wrEn;
        logic [AW-1:0] wrReg0;
        logic [DW-1:0] wrData0;
        logic [AW-1:0] wrReg1;
        logic [DW-1:0] wrData1;
        logic          rsvEn;
        logic [AW-1:0] rsvReg;
        logic [AW-1:0] rdReg0;
        logic [AW-1:0] rdReg1;
        logic [DW-1:0] expRd0;
        logic [DW-1:0] expRd1;
        logic          expBusy0;
        logic          expBusy1;
        logic [DW-1:0] expNbRd0;
        logic          expNbBusy0;
        logic [NR-1:0] expBusyVec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_file_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) bus ();
    register_file_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)) busNb ();

    assign busNb.rd_reg  = bus.rd_reg;
    assign busNb.wr_en   = bus.wr_en;
    assign busNb.wr_reg  = bus.wr_reg;
    assign busNb.wr_data = bus.wr_data;
    assign busNb.rsv_en  = bus.rsv_en;
    assign busNb.rsv_reg = bus.rsv_reg;

    register_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    register_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .BYPASS(0)) dutNb (
        .clk(clk), .rst_n(rst_n), .bus(busNb.slave)
    );

    int checks = 0;
    int errors = 0;
    int prioHits = 0;
    int rsvWrHits = 0;
    logic [DW-1:0] refMem [NR];
    bit refBusy [NR];
    vec_t vecs [15];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        bus.wr_en   = '0;
        bus.wr_reg  = '0;
        bus.wr_data = '0;
        bus.rsv_en  = 1'b0;
        bus.rsv_reg = '0;
        bus.rd_reg  = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.wr_en      = v.wrEn;
        bus.wr_reg[0]  = v.wrReg0;
        bus.wr_data[0] = v.wrData0;
        bus.wr_reg[1]  = v.wrReg1;
        bus.wr_data[1] = v.wrData1;
        bus.rsv_en     = v.rsvEn;
        bus.rsv_reg    = v.rsvReg;
        bus.rd_reg[0]  = v.rdReg0;
        bus.rd_reg[1]  = v.rdReg1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            refMem[i]  = '0;
            refBusy[i] = 1'b0;
        end
    endtask

    function automatic bit writtenNow(input int a);
        for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && int'(bus.wr_reg[p]) == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Highest-numbered enabled writer to the address is the one a reader sees.
    function automatic logic [DW-1:0] refRead(input int a, input bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp) begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (bus.wr_en[p] && int'(bus.wr_reg[p]) == a) return bus.wr_data[p];
            end
        end
        return refMem[a];
    endfunction

    function automatic logic refBusyRd(input int a, input bit byp);
        if (!rst_n || a == 0) return 1'b0;
        if (byp && writtenNow(a) && !(bus.rsv_en && int'(bus.rsv_reg) == a)) return 1'b0;
        return refBusy[a];
    endfunction

    function automatic logic [NR-1:0] refBusyVec();
        logic [NR-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i] = refBusy[i];
        return v;
    endfunction

    task automatic modelUpdate();
        if (!rst_n) begin
            modelReset();
        end else begin
            for (int a = 1; a < NR; a++) begin
                bit rsvHit;
                rsvHit = bus.rsv_en && int'(bus.rsv_reg) == a;
                if (writtenNow(a)) begin
                    refMem[a] = refRead(a, 1'b1);
                end
                if (rsvHit) refBusy[a] = 1'b1;
                else if (writtenNow(a)) refBusy[a] = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int r = 0; r < NRD; r++) begin
            check($sformatf("%s byp rd_data%0d", tag, r), bus.rd_data[r], refRead(int'(bus.rd_reg[r]), 1'b1));
            check($sformatf("%s byp rd_busy%0d", tag, r), DW'(bus.rd_busy[r]), DW'(refBusyRd(int'(bus.rd_reg[r]), 1'b1)));
            check($sformatf("%s nobyp rd_data%0d", tag, r), busNb.rd_data[r], refRead(int'(bus.rd_reg[r]), 1'b0));
            check($sformatf("%s nobyp rd_busy%0d", tag, r), DW'(busNb.rd_busy[r]), DW'(refBusyRd(int'(bus.rd_reg[r]), 1'b0)));
        end
        check($sformatf("%s byp busy_vec", tag), bus.busy_vec, refBusyVec());
        check($sformatf("%s nobyp busy_vec", tag), busNb.busy_vec, refBusyVec());
    endtask

    task automatic stepCycle(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        vecs[0]  = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 5'd7,
                     32'h22222222, 32'h22222222, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3,
                     32'h22222222, 32'h0, 1'b0, 1'b0, 32'h22222222, 1'b0, 32'h0};
        vecs[4]  = '{2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9,
                     32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                     32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h200};
        vecs[8]  = vecs[7];
        vecs[9]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h5, 1'b0, 5'd0, 5'd9, 5'd9,
                     32'h5, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200};
        vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                     32'h5, 32'h5, 1'b0, 1'b0, 32'h5, 1'b0, 32'h0};
        vecs[11] = '{2'b01, 5'd12, 32'h7, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd12,
                     32'h7, 32'h7, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd12,
                     32'h7, 32'h7, 1'b1, 1'b1, 32'h7, 1'b1, 32'h1000};
        vecs[13] = '{2'b01, 5'd12, 32'h8, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd7,
                     32'h8, 32'h22222222, 1'b0, 1'b0, 32'h7, 1'b1, 32'h1000};
        vecs[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd3,
                     32'h8, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h8, 1'b0, 32'h0};

        rst_n = 1'b0;
        setIdle();
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_reg[0] = 5'd5;
        stepCycle("after reset");

        // Load x5 and mark it pending, then drop reset between edges with a write in flight.
        bus.wr_en      = 2'b01;
        bus.wr_reg[0]  = 5'd5;
        bus.wr_data[0] = 32'hDEADBEEF;
        bus.rsv_en     = 1'b1;
        bus.rsv_reg    = 5'd5;
        stepCycle("x5 load");
        setIdle();
        bus.rd_reg[0] = 5'd5;
        @(negedge clk);
        check("x5 stored", bus.rd_data[0], 32'hDEADBEEF);
        check("x5 busy_vec", bus.busy_vec, 32'h20);
        bus.wr_en      = 2'b01;
        bus.wr_reg[0]  = 5'd5;
        bus.wr_data[0] = 32'h12345678;
        rst_n = 1'b0;
        #1;
        modelReset();
        check("async reset rd_data", bus.rd_data[0], 32'h0);
        check("async reset rd_busy", DW'(bus.rd_busy[0]), 32'h0);
        check("async reset busy_vec", bus.busy_vec, 32'h0);
        check("async reset nobyp rd_data", busNb.rd_data[0], 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset hold rd_data", bus.rd_data[0], 32'h0);
        check("reset hold nobyp rd_data", busNb.rd_data[0], 32'h0);
        setIdle();
        bus.rd_reg[0] = 5'd5;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stepCycle("post release");

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d rd0", i), bus.rd_data[0], vecs[i].expRd0);
            check($sformatf("vec%0d rd1", i), bus.rd_data[1], vecs[i].expRd1);
            check($sformatf("vec%0d busy0", i), DW'(bus.rd_busy[0]), DW'(vecs[i].expBusy0));
            check($sformatf("vec%0d busy1", i), DW'(bus.rd_busy[1]), DW'(vecs[i].expBusy1));
            check($sformatf("vec%0d nobyp rd0", i), busNb.rd_data[0], vecs[i].expNbRd0);
            check($sformatf("vec%0d nobyp busy0", i), DW'(busNb.rd_busy[0]), DW'(vecs[i].expNbBusy0));
            check($sformatf("vec%0d busy_vec", i), bus.busy_vec, vecs[i].expBusyVec);
            checkOutput($sformatf("vec%0d model", i));
            @(posedge clk);
            modelUpdate();
            #1;
        end

        // Narrow address range most of the time so port collisions and aliasing are frequent.
        for (int c = 0; c < 1000; c++) begin
            for (int p = 0; p < NWR; p++) begin
                bus.wr_en[p]   = ($urandom_range(0, 2) != 0);
                bus.wr_reg[p]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
                bus.wr_data[p] = $urandom;
            end
            bus.rsv_en  = ($urandom_range(0, 3) == 0);
            bus.rsv_reg = ($urandom_range(0, 1) == 0) ? bus.wr_reg[$urandom_range(0, NWR - 1)] : AW'($urandom_range(0, 7));
            for (int r = 0; r < NRD; r++) begin
                bus.rd_reg[r] = ($urandom_range(0, 1) == 0) ? bus.wr_reg[$urandom_range(0, NWR - 1)] : AW'($urandom_range(0, NR - 1));
            end
            if (bus.wr_en == 2'b11 && bus.wr_reg[0] == bus.wr_reg[1] && bus.wr_reg[0] != '0) prioHits++;
            if (bus.rsv_en && bus.rsv_reg != '0 && writtenNow(int'(bus.rsv_reg))) rsvWrHits++;
            stepCycle($sformatf("rand%0d", c));
        end
        check("coverage port priority hit", DW'(prioHits > 0), 32'h1);
        check("coverage reserve+write hit", DW'(rsvWrHits > 0), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the next-generation pipelined RISC-V core. It generalises the single-write, dual-read register file to configurable depth, width, read-port count and write-port count. It adds optional write-to-read bypass, an asynchronous clear, and a per-register busy scoreboard so decode can detect pending writebacks. It sits between decode (reads, reservations) and writeback (writes).

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, register count; power of two, >= 2
NUM_RD_PORTS, 2, independent combinational read ports
NUM_WR_PORTS, 2, independent synchronous write ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only
(local) ADDR_W = clog2(NUM_REGS)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rd_reg  in  NUM_RD_PORTS x ADDR_W  read address per port
rd_data  out  NUM_RD_PORTS x DATA_WIDTH  read data per port
rd_busy  out  NUM_RD_PORTS  busy bit of addressed register per port
wr_en  in  NUM_WR_PORTS  write enable per port
wr_reg  in  NUM_WR_PORTS x ADDR_W  write address per port
wr_data  in  NUM_WR_PORTS x DATA_WIDTH  write data per port
rsv_en  in  1  reserve (mark busy) request
rsv_reg  in  ADDR_W  register to reserve
busy_vec  out  NUM_REGS  full scoreboard, bit i = register i pending

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - On rst_n low: all registers clear to 0 and all busy bits clear to 0, immediately, without waiting for a clock edge.
  - While rst_n is low, writes and reservations are ignored. rd_data reads 0 and rd_busy reads 0.
  - Release is clean on the first clk edge after rst_n goes high.
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0 regardless of bypass.
  - Reserving address 0 is ignored; busy_vec[0] is always 0.
- Writes: on the rising clk edge, each port with wr_en=1 updates mem[wr_reg] with wr_data. Latency is 1 cycle to storage.
- Write-write conflict: if several enabled ports target the same nonzero register in one cycle, the highest-indexed port wins. Lower ports to that address have no effect.
- Reads are combinational with 0 cycles of latency:
  - BYPASS=1: if any enabled write port targets rd_reg (nonzero) this cycle, rd_data is that write data, using the same highest-index priority. Otherwise rd_data is the stored value.
  - BYPASS=0: rd_data always shows the stored value; the new value appears the cycle after the write.
- Scoreboard, per register, registered:
  - rsv_en with nonzero rsv_reg sets busy[rsv_reg] at the edge.
  - An enabled write to a register clears its busy bit at the edge.
  - Reserve and write to the same register in the same cycle: reserve wins and the bit stays/becomes 1, because a newer producer is in flight.
  - Reserving an already-busy register leaves it at 1 (no counting).
- rd_busy[p] = busy_vec[rd_reg[p]], combinationally.
  - With BYPASS=1, a same-cycle write to that register (and no same-cycle reserve of it) forces rd_busy[p]=0, consistent with the forwarded data.
  - With BYPASS=0, rd_busy shows the registered bit only.
- Any read port may alias any other read port or any write port; there are no structural hazards.
- Reset asserted mid-write loses that write; the scoreboard clears.

Test Plan:
1. Assert rst_n=0 for 2 cycles after writing 0xDEADBEEF to x5, then release -> x5 reads 0x00000000 and busy_vec=0 immediately on assertion, with no clk edge needed.
2. Write 0xFFFFFFFF to x0 via both ports; rsv_reg=0, rsv_en=1 -> rd_data for x0 = 0 and busy_vec[0]=0.
3. Same cycle: port0 writes x7=0x11111111, port1 writes x7=0x22222222 -> next cycle x7 reads 0x22222222. With BYPASS=1, the same-cycle read of x7 also returns 0x22222222.
4. BYPASS=1: write x3=0xA5A5A5A5 and read x3 on both ports in the same cycle -> both return 0xA5A5A5A5. BYPASS=0 build: the same stimulus returns the old value (0) that cycle and 0xA5A5A5A5 the next.
5. Reserve x9 at cycle N -> busy_vec[9]=1 from N+1 and rd_busy=1 when reading x9. Write x9=0x5 at cycle N+3 -> busy clears at N+4; with BYPASS=1, rd_busy=0 and rd_data=0x5 during N+3.
6. Reserve x12 and write x12=0x7 in the same cycle -> x12 stores 0x7 and busy_vec[12] stays 1. Then run 1000 random cycles against the reference model and coverage: 0 mismatches, with every write-port priority case hit.
